// File: rtl/hud_number_renderer.sv
// hud_number_renderer
// Draws N_FIELDS unsigned numeric fields into an RGB565 framebuffer as
// DIGITS-wide decimal numbers using an external 8x16 1bpp digit ROM.
// Only fields whose value changed since they were last drawn (or that
// were forced by reset/refresh) are redrawn.
//
// Ports
//   clk_i          sole clock, rising edge
//   rst_i          synchronous active-high reset
//   values_i       packed field values, field f at [f*VALUE_W +: VALUE_W]
//   refresh_i      single-cycle request to redraw every field
//   glyph_addr_o   {digit[3:0], row[3:0]} into the digit ROM
//   glyph_row_i    ROM row data, one cycle after glyph_addr_o, bit 7 leftmost
//   dst_addr_o     framebuffer pixel address
//   dst_data_o     pixel colour
//   dst_wr_o       pixel write request
//   dst_ready_i    sink accepts the write when dst_wr_o & dst_ready_i
//   busy_o         high whenever the renderer is not idle
//   frame_done_o   one-cycle pulse once all dirty fields have been drawn
module hud_number_renderer #(
    parameter int          N_FIELDS = 6,
    parameter int          DIGITS   = 4,
    parameter int          VALUE_W  = 16,
    parameter int          FB_W     = 640,
    parameter int          FIELD_X0 = 16,
    parameter int          FIELD_Y0 = 16,
    parameter int          FIELD_DY = 24,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_FIELDS*VALUE_W-1:0]  values_i,
    input  logic                         refresh_i,
    output logic [7:0]                   glyph_addr_o,
    input  logic [7:0]                   glyph_row_i,
    output logic [18:0]                  dst_addr_o,
    output logic [15:0]                  dst_data_o,
    output logic                         dst_wr_o,
    input  logic                         dst_ready_i,
    output logic                         busy_o,
    output logic                         frame_done_o
);

    localparam int FW = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int BW = DIGITS * 4;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Smallest value that no longer fits in DIGITS decimal positions.
    localparam logic [63:0] DEC_LIMIT = pow10(DIGITS);

    typedef enum logic [2:0] {
        IDLE, SCAN, CONV, FETCH, WAIT, EMIT, NEXT
    } state_t;

    state_t               state_q, state_d;
    logic [FW-1:0]        field_q, field_d;
    logic [VALUE_W-1:0]   snap_q, snap_d;
    logic                 sat_q, sat_d;
    logic [VALUE_W-1:0]   shift_q, shift_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic [CW-1:0]        convCnt_q, convCnt_d;
    logic [DW-1:0]        digit_q, digit_d;
    logic [3:0]           row_q, row_d;
    logic [2:0]           col_q, col_d;
    logic [7:0]           rowData_q, rowData_d;
    logic                 drewAny_q, drewAny_d;
    logic [N_FIELDS-1:0]  forceFlag_q, forceFlag_d;
    logic [VALUE_W-1:0]   shadow_q [N_FIELDS];
    logic                 shadowWe;
    logic                 frameDone;

    logic [N_FIELDS-1:0]  dirty;
    logic                 anyDirty;
    logic [FW-1:0]        pickIdx;
    logic [VALUE_W-1:0]   pickValue;

    logic [BW-1:0]        bcdAdj;
    logic                 leadZero;
    logic [3:0]           curNib;
    logic                 curBlank;

    logic [31:0]          pixRow;
    logic [31:0]          pixCol;
    logic [18:0]          pixAddr;
    logic [15:0]          pixColor;

    // Dirty detection: a field needs drawing when its live value differs
    // from what was last drawn or when it has been forced. Scanning from the
    // top down leaves the lowest-index dirty field selected.
    always_comb begin
        dirty     = '0;
        pickIdx   = '0;
        pickValue = '0;
        for (int f = N_FIELDS - 1; f >= 0; f--) begin
            dirty[f] = (values_i[f*VALUE_W +: VALUE_W] != shadow_q[f]) || forceFlag_q[f];
            if (dirty[f]) begin
                pickIdx   = FW'(f);
                pickValue = values_i[f*VALUE_W +: VALUE_W];
            end
        end
        anyDirty = |dirty;
    end

    // Double-dabble add-3 correction applied to every BCD nibble before the
    // shift. Overflow above DIGITS digits is dropped here; saturation covers it.
    always_comb begin
        bcdAdj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcdAdj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end else begin
                bcdAdj[i*4 +: 4] = bcd_q[i*4 +: 4];
            end
        end
    end

    // Glyph for the digit position being drawn. A position is blanked while
    // it and every more significant digit are zero, except the last position
    // so that zero still shows a single '0'. Saturation overrides everything.
    always_comb begin
        leadZero = 1'b1;
        curNib   = 4'd0;
        curBlank = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[(DIGITS-1-d)*4 +: 4] != 4'd0) begin
                leadZero = 1'b0;
            end
            if (int'(digit_q) == d) begin
                curNib   = bcd_q[(DIGITS-1-d)*4 +: 4];
                curBlank = leadZero && (d != DIGITS - 1);
            end
        end
        if (sat_q) begin
            curNib   = 4'd9;
            curBlank = 1'b0;
        end
    end

    // Pixel address and colour for the current field/digit/row/column.
    // Wrapping to 19 bits is intentional: the framebuffer address is modular.
    always_comb begin
        pixRow   = 32'(FIELD_Y0) + 32'(field_q) * 32'(FIELD_DY) + 32'(row_q);
        pixCol   = 32'(FIELD_X0) + 32'(digit_q) * 32'd8 + 32'(col_q);
        pixAddr  = 19'(pixRow * 32'(FB_W) + pixCol);
        pixColor = (!curBlank && rowData_q[3'd7 - col_q]) ? FG_COLOR : BG_COLOR;
    end

    // Next-state and datapath control. Row/digit counters are advanced on
    // leaving EMIT so that they already point at the next glyph row during
    // FETCH. Counters only move on an accepted write, which keeps the write
    // outputs frozen through any stall.
    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        snap_d      = snap_q;
        sat_d       = sat_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        convCnt_d   = convCnt_q;
        digit_d     = digit_q;
        row_d       = row_q;
        col_d       = col_q;
        rowData_d   = rowData_q;
        drewAny_d   = drewAny_q;
        forceFlag_d = forceFlag_q;
        shadowWe    = 1'b0;
        frameDone   = 1'b0;

        case (state_q)
            IDLE: begin
                if (anyDirty) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (anyDirty) begin
                    field_d              = pickIdx;
                    snap_d               = pickValue;
                    sat_d                = (64'(pickValue) >= DEC_LIMIT);
                    shift_d              = pickValue;
                    bcd_d                = '0;
                    convCnt_d            = '0;
                    forceFlag_d[pickIdx] = 1'b0;
                    state_d              = CONV;
                end else begin
                    frameDone = drewAny_q;
                    drewAny_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            CONV: begin
                bcd_d   = BW'({bcdAdj, shift_q[VALUE_W-1]});
                shift_d = shift_q << 1;
                if (convCnt_q == CW'(VALUE_W - 1)) begin
                    digit_d = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = FETCH;
                end else begin
                    convCnt_d = convCnt_q + 1'b1;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                rowData_d = glyph_row_i;
                state_d   = EMIT;
            end
            EMIT: begin
                if (dst_ready_i) begin
                    if (col_q == 3'd7) begin
                        col_d = '0;
                        if (row_q == 4'd15) begin
                            row_d = '0;
                            if (digit_q == DW'(DIGITS - 1)) begin
                                state_d = NEXT;
                            end else begin
                                digit_d = digit_q + 1'b1;
                                state_d = FETCH;
                            end
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            NEXT: begin
                shadowWe  = 1'b1;
                drewAny_d = 1'b1;
                state_d   = SCAN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A refresh wins over the flag clear in SCAN so no request is lost.
        if (refresh_i) begin
            forceFlag_d = '1;
        end
    end

    // State and datapath registers. Reset forces every field so the whole
    // HUD is redrawn once the renderer comes out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            field_q     <= '0;
            snap_q      <= '0;
            sat_q       <= 1'b0;
            shift_q     <= '0;
            bcd_q       <= '0;
            convCnt_q   <= '0;
            digit_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            rowData_q   <= '0;
            drewAny_q   <= 1'b0;
            forceFlag_q <= '1;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            snap_q      <= snap_d;
            sat_q       <= sat_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            convCnt_q   <= convCnt_d;
            digit_q     <= digit_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rowData_q   <= rowData_d;
            drewAny_q   <= drewAny_d;
            forceFlag_q <= forceFlag_d;
        end
    end

    // Shadow copies of the last drawn values. They are deliberately not
    // cleared by reset: the forced redraw makes their content irrelevant,
    // and a field abandoned by reset must not be recorded as drawn.
    always_ff @(posedge clk_i) begin
        if (!rst_i && shadowWe) begin
            shadow_q[field_q] <= snap_q;
        end
    end

    assign glyph_addr_o = {curNib, row_q};
    assign dst_wr_o     = (state_q == EMIT);
    assign dst_addr_o   = (state_q == EMIT) ? pixAddr : 19'd0;
    assign dst_data_o   = (state_q == EMIT) ? pixColor : 16'd0;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frameDone;

endmodule

// File: tb/tb_hud_number_renderer.sv
// Testbench for hud_number_renderer with default parameters.
// Expected pixel writes are generated by a decimal model and queued when a
// value change is driven; every accepted write pops and checks one entry.
module tb_hud_number_renderer;

    localparam int          N_FIELDS = 6;
    localparam int          DIGITS   = 4;
    localparam int          VALUE_W  = 16;
    localparam int          FB_W     = 640;
    localparam int          FIELD_X0 = 16;
    localparam int          FIELD_Y0 = 16;
    localparam int          FIELD_DY = 24;
    localparam logic [15:0] FG       = 16'hFFFF;
    localparam logic [15:0] BG       = 16'h0000;

    typedef struct packed {
        logic [18:0] addr;
        logic [15:0] data;
    } pix_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [N_FIELDS*VALUE_W-1:0] values = '0;
    logic                        refresh = 1'b0;
    logic [7:0]                  glyph_addr;
    logic [7:0]                  glyph_row = 8'h00;
    logic [18:0]                 dst_addr;
    logic [15:0]                 dst_data;
    logic                        dst_wr;
    logic                        dst_ready = 1'b1;
    logic                        busy;
    logic                        frame_done;

    pix_t expQ[$];
    int   nCompared  = 0;
    int   nMismatch  = 0;
    int   writeCount = 0;
    int   pulseCount = 0;
    logic [18:0] firstAddr = '0;
    bit   sbEnable    = 1'b0;
    bit   randomReady = 1'b0;
    bit   stallPrev   = 1'b0;
    pix_t stallPix    = '0;
    pix_t popped      = '0;

    hud_number_renderer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .values_i     (values),
        .refresh_i    (refresh),
        .glyph_addr_o (glyph_addr),
        .glyph_row_i  (glyph_row),
        .dst_addr_o   (dst_addr),
        .dst_data_o   (dst_data),
        .dst_wr_o     (dst_wr),
        .dst_ready_i  (dst_ready),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    // Digit ROM: every address has a distinct pattern, so a wrong digit or
    // row shows up in the drawn pixels.
    always @(posedge clk) begin
        glyph_row <= glyph_addr ^ 8'h5A;
    end

    // Sink ready: always high, or a 50% coin toss per cycle when enabled.
    always @(posedge clk) begin
        #1;
        dst_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Write monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_done) pulseCount++;
        if (sbEnable && stallPrev) begin
            nCompared++;
            if (dst_wr !== 1'b1 || dst_addr !== stallPix.addr || dst_data !== stallPix.data) begin
                nMismatch++;
                $display("[TB] FAIL stall_hold: got wr=%b addr=%0d data=%h, required wr=1 addr=%0d data=%h",
                         dst_wr, dst_addr, dst_data, stallPix.addr, stallPix.data);
            end
        end
        stallPrev = dst_wr && !dst_ready;
        stallPix  = '{addr: dst_addr, data: dst_data};
        if (dst_wr && dst_ready) begin
            if (writeCount == 0) firstAddr = dst_addr;
            writeCount++;
            if (sbEnable) begin
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatch++;
                    $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write",
                             dst_addr, dst_data);
                end else begin
                    popped = expQ.pop_front();
                    if (dst_addr !== popped.addr || dst_data !== popped.data) begin
                        nMismatch++;
                        $display("[TB] FAIL pixel: got addr=%0d data=%h, required addr=%0d data=%h",
                                 dst_addr, dst_data, popped.addr, popped.data);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Decimal model of one field draw: pushes all DIGITS*128 expected pixels.
    task automatic pushField(input int f, input int v);
        int          dg[DIGITS];
        int          tmp;
        bit          sat;
        bit          lead;
        bit          blank;
        int          g;
        int          a;
        logic [7:0]  rowBits;
        sat = (v >= 10**DIGITS);
        tmp = v;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            dg[d] = tmp % 10;
            tmp   = tmp / 10;
        end
        lead = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (dg[d] != 0) lead = 1'b0;
            blank = !sat && lead && (d != DIGITS - 1);
            g     = sat ? 9 : dg[d];
            for (int row = 0; row < 16; row++) begin
                rowBits = {4'(g), 4'(row)} ^ 8'h5A;
                for (int col = 0; col < 8; col++) begin
                    a = ((FIELD_Y0 + f*FIELD_DY + row) * FB_W + FIELD_X0 + d*8 + col) % 524288;
                    expQ.push_back('{addr: 19'(a), data: (!blank && rowBits[7-col]) ? FG : BG});
                end
            end
        end
    endtask

    task automatic setField(input int f, input int v);
        values[f*VALUE_W +: VALUE_W] = 16'(v);
    endtask

    // Waits (bounded) for the next frame_done pulse, then lets the design settle.
    task automatic waitFrameDone(input string name, input int budget);
        int start;
        int n;
        start = pulseCount;
        n     = 0;
        while (pulseCount == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (pulseCount == start) begin
            nCompared++;
            nMismatch++;
            $display("[TB] FAIL %s_timeout: got no frame_done in %0d cycles, required a pulse", name, budget);
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        values = '0;
        repeat (4) @(posedge clk);
        #1;
        nCompared += 6;
        if (dst_wr !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_wr: got %b, required 0", dst_wr); end
        if (dst_addr !== 19'd0) begin nMismatch++; $display("[TB] FAIL reset_addr: got %0d, required 0", dst_addr); end
        if (dst_data !== 16'd0) begin nMismatch++; $display("[TB] FAIL reset_data: got %h, required 0", dst_data); end
        if (glyph_addr !== 8'd0) begin nMismatch++; $display("[TB] FAIL reset_glyph: got %h, required 0", glyph_addr); end
        if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        if (frame_done !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_frame_done: got %b, required 0", frame_done); end
    endtask

    task automatic test_initial_draw();
        int p0;
        expQ.delete();
        for (int f = 0; f < N_FIELDS; f++) pushField(f, 0);
        sbEnable   = 1'b1;
        writeCount = 0;
        p0         = pulseCount;
        rst        = 1'b0;
        waitFrameDone("initial", 8000);
        nCompared += 4;
        if (writeCount != 3072) begin nMismatch++; $display("[TB] FAIL initial_writes: got %0d, required 3072", writeCount); end
        if (pulseCount - p0 != 1) begin nMismatch++; $display("[TB] FAIL initial_pulses: got %0d, required 1", pulseCount - p0); end
        if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL initial_busy: got %b, required 0", busy); end
        if (expQ.size() != 0) begin nMismatch++; $display("[TB] FAIL initial_leftover: got %0d pending, required 0", expQ.size()); end
    endtask

    task automatic test_single_field();
        int p0;
        writeCount = 0;
        p0         = pulseCount;
        setField(1, 1234);
        pushField(1, 1234);
        waitFrameDone("single", 3000);
        nCompared += 4;
        if (writeCount != 512) begin nMismatch++; $display("[TB] FAIL single_writes: got %0d, required 512", writeCount); end
        if (firstAddr !== 19'd25616) begin nMismatch++; $display("[TB] FAIL single_first_addr: got %0d, required 25616", firstAddr); end
        if (pulseCount - p0 != 1) begin nMismatch++; $display("[TB] FAIL single_pulses: got %0d, required 1", pulseCount - p0); end
        if (expQ.size() != 0) begin nMismatch++; $display("[TB] FAIL single_leftover: got %0d pending, required 0", expQ.size()); end
    endtask

    task automatic test_saturate();
        int p0;
        writeCount = 0;
        p0         = pulseCount;
        setField(2, 12345);
        setField(3, 7);
        pushField(2, 12345);
        pushField(3, 7);
        waitFrameDone("saturate", 5000);
        nCompared += 3;
        if (writeCount != 1024) begin nMismatch++; $display("[TB] FAIL saturate_writes: got %0d, required 1024", writeCount); end
        if (pulseCount - p0 != 1) begin nMismatch++; $display("[TB] FAIL saturate_pulses: got %0d, required 1", pulseCount - p0); end
        if (expQ.size() != 0) begin nMismatch++; $display("[TB] FAIL saturate_leftover: got %0d pending, required 0", expQ.size()); end
    endtask

    task automatic test_backpressure();
        int p0;
        setField(1, 0);
        pushField(1, 0);
        waitFrameDone("bp_clear", 3000);
        randomReady = 1'b1;
        writeCount  = 0;
        p0          = pulseCount;
        setField(1, 1234);
        pushField(1, 1234);
        waitFrameDone("backpressure", 8000);
        randomReady = 1'b0;
        nCompared += 4;
        if (writeCount != 512) begin nMismatch++; $display("[TB] FAIL bp_writes: got %0d, required 512", writeCount); end
        if (firstAddr !== 19'd25616) begin nMismatch++; $display("[TB] FAIL bp_first_addr: got %0d, required 25616", firstAddr); end
        if (pulseCount - p0 != 1) begin nMismatch++; $display("[TB] FAIL bp_pulses: got %0d, required 1", pulseCount - p0); end
        if (expQ.size() != 0) begin nMismatch++; $display("[TB] FAIL bp_leftover: got %0d pending, required 0", expQ.size()); end
    endtask

    task automatic test_change_during_draw();
        int p0;
        int n;
        setField(1, 9);
        pushField(1, 9);
        waitFrameDone("change_prep", 3000);
        writeCount = 0;
        p0         = pulseCount;
        setField(1, 1234);
        pushField(1, 1234);
        n = 0;
        while (writeCount < 100 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        nCompared++;
        if (writeCount < 100) begin nMismatch++; $display("[TB] FAIL change_start: got %0d writes, required >= 100", writeCount); end
        setField(1, 42);
        pushField(1, 42);
        waitFrameDone("change", 5000);
        nCompared += 3;
        if (writeCount != 1024) begin nMismatch++; $display("[TB] FAIL change_writes: got %0d, required 1024", writeCount); end
        if (pulseCount - p0 != 1) begin nMismatch++; $display("[TB] FAIL change_pulses: got %0d, required 1", pulseCount - p0); end
        if (expQ.size() != 0) begin nMismatch++; $display("[TB] FAIL change_leftover: got %0d pending, required 0", expQ.size()); end
    endtask

    task automatic test_reset_mid_draw();
        int p0;
        int n;
        sbEnable   = 1'b0;
        writeCount = 0;
        setField(0, 55);
        n = 0;
        while (writeCount < 40 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        nCompared++;
        if (writeCount < 40) begin nMismatch++; $display("[TB] FAIL rstmid_start: got %0d writes, required >= 40", writeCount); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        nCompared += 2;
        if (dst_wr !== 1'b0) begin nMismatch++; $display("[TB] FAIL rstmid_wr: got %b, required 0", dst_wr); end
        if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL rstmid_busy: got %b, required 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        expQ.delete();
        pushField(0, 55);
        pushField(1, 42);
        pushField(2, 12345);
        pushField(3, 7);
        pushField(4, 0);
        pushField(5, 0);
        sbEnable   = 1'b1;
        writeCount = 0;
        p0         = pulseCount;
        rst        = 1'b0;
        refresh    = 1'b1;
        @(posedge clk);
        #1;
        refresh = 1'b0;
        waitFrameDone("rstmid", 8000);
        nCompared += 4;
        if (writeCount != 3072) begin nMismatch++; $display("[TB] FAIL rstmid_writes: got %0d, required 3072", writeCount); end
        if (pulseCount - p0 != 1) begin nMismatch++; $display("[TB] FAIL rstmid_pulses: got %0d, required 1", pulseCount - p0); end
        if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL rstmid_busy_end: got %b, required 0", busy); end
        if (expQ.size() != 0) begin nMismatch++; $display("[TB] FAIL rstmid_leftover: got %0d pending, required 0", expQ.size()); end
    endtask

    initial begin
        test_reset();
        test_initial_draw();
        test_single_field();
        test_saturate();
        test_backpressure();
        test_change_during_draw();
        test_reset_mid_draw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/hud_number_renderer.md
HUD_NUMBER_RENDERER -- requirements
Module: hud_number_renderer

Interface
REQ-001 Parameter N_FIELDS, default 6: number of independent numeric fields drawn.
REQ-002 Parameter DIGITS, default 4: decimal digit positions per field, range 1..8.
REQ-003 Parameter VALUE_W, default 16: width of each field value, unsigned binary.
REQ-004 Parameter FB_W, default 640: framebuffer stride in pixels.
REQ-005 Parameters FIELD_X0=16, FIELD_Y0=16, FIELD_DY=24: pixel origin of field 0 and vertical pitch between fields.
REQ-006 Parameters FG_COLOR=16'hFFFF, BG_COLOR=16'h0000: RGB565 colours for set and clear glyph bits.
REQ-007 Clocking: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  sole clock, all logic on rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 values  in  N_FIELDS*VALUE_W  packed field values, field f at [f*VALUE_W +: VALUE_W].
REQ-011 refresh  in  1  single-cycle request to redraw every field.
REQ-012 glyph_addr  out  8  {digit[3:0], row[3:0]} into 8x16 1bpp digit ROM; digit 0..9.
REQ-013 glyph_row  in  8  ROM row data, valid exactly 1 cycle after glyph_addr; bit 7 = leftmost pixel.
REQ-014 dst_addr  out  19  framebuffer pixel address.
REQ-015 dst_data  out  16  pixel colour.
REQ-016 dst_wr  out  1  pixel write request.
REQ-017 dst_ready  in  1  sink accepts the write on a cycle where dst_wr & dst_ready.
REQ-018 busy  out  1  high while any field is converting or drawing.
REQ-019 frame_done  out  1  one-cycle pulse when all dirty fields are drawn.

Function
REQ-020 Each field shall keep a shadow register of its last drawn value plus a force flag; the field is dirty when values[f] != shadow[f] or force[f]=1.
REQ-021 FSM states: IDLE, SCAN, CONV, FETCH, WAIT, EMIT, NEXT; IDLE->SCAN every cycle when any field is dirty.
REQ-022 SCAN shall select the lowest-index dirty field, snapshot its value, clear its force flag, and enter CONV.
REQ-023 CONV shall run sequential double-dabble conversion, exactly VALUE_W cycles, into DIGITS BCD digits.
REQ-024 Snapshot >= 10^DIGITS shall saturate: every digit drawn as 9.
REQ-025 Leading-zero blanking: digit positions above the most significant nonzero digit are drawn fully BG_COLOR; value 0 draws a single '0' in the least significant position.
REQ-026 Drawing order: digit d=0 (most significant, leftmost) to DIGITS-1; within a digit, row 0..15; within a row, col 0..7.
REQ-027 Pixel address = ((FIELD_Y0 + f*FIELD_DY + row)*FB_W + FIELD_X0 + d*8 + col) mod 2^19.
REQ-028 Per row: FETCH drives glyph_addr (1 cycle); WAIT captures glyph_row (1 cycle); EMIT issues 8 pixels; with dst_ready held high a row takes exactly 10 cycles.
REQ-029 Blanked digits still emit all 128 pixels in BG_COLOR; the ROM read is don't-care.
REQ-030 dst_addr, dst_data, dst_wr shall be held stable while dst_wr=1 and dst_ready=0; no pixel dropped or duplicated.
REQ-031 After the last pixel of a field is accepted, NEXT writes the snapshot to shadow[f] and returns to SCAN.
REQ-032 A value change during its own field's draw shall not disturb that draw; the field stays dirty and is redrawn afterwards.
REQ-033 refresh shall set all force flags, at any state; fields already drawn in the current pass are redrawn.
REQ-034 frame_done shall pulse for one cycle when SCAN finds no dirty field after at least one field was drawn since the previous pulse; the FSM then enters IDLE.
REQ-035 busy shall be high in every state except IDLE.

Reset
REQ-036 On rst: dst_wr=0, dst_addr=0, dst_data=0, glyph_addr=0, busy=0, frame_done=0, state IDLE.
REQ-037 On rst: all force flags set; fields fully redraw after reset.
REQ-038 rst mid-operation shall abandon the current field with no further writes; that field's shadow is not updated.

Verification
REQ-039 Release rst, values all 0, dst_ready=1 -> 3072 writes (6 fields x 4 digits x 128); each field shows blank,blank,blank,'0'; one frame_done pulse; busy low afterwards.
REQ-040 Then set field 1 to 1234 -> exactly 512 writes, first dst_addr = 40*640+16 = 25616, glyph_addr digit sequence 1,2,3,4; other fields untouched.
REQ-041 Field 2 set to 12345 (DIGITS=4) -> drawn as 9999; field 3 set to 7 -> blank,blank,blank,'7'.
REQ-042 Repeat REQ-040 with dst_ready random at 50% -> identical accepted address/data sequence; outputs stable across every stall.
REQ-043 Change field 1 from 1234 to 42 during its draw -> 1234 completes, then 42 is fully redrawn, two frame_done-free passes merge into one pulse.
REQ-044 Assert rst during EMIT, then refresh after release -> dst_wr=0 on the next cycle; full 3072-write redraw follows.
